// File: rtl/arb_mux_reg_pkg.sv
// Shared constants and helpers for the arbitrated, registered N-to-1 multiplexer.
package arb_mux_reg_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_NUM_CH = 4;

    // Bits needed to index n items, never less than one so a 1-bit index still exists.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Combinational round-robin / fixed-priority arbiter producing a one-hot grant and its index.
module rr_arbiter
    import arb_mux_reg_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int CH_W   = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              fixed_prio,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [NUM_CH-1:0] upper_mask;
    logic [NUM_CH-1:0] masked_req;
    logic [NUM_CH-1:0] masked_low;
    logic [NUM_CH-1:0] req_low;

    // Channels at or above the pointer get first pick; fixed mode opens the whole range
    // so the lowest requester wins.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
            assign upper_mask[gi] = fixed_prio || (CH_W'(gi) >= ptr);
        end
    endgenerate

    assign masked_req = req & upper_mask;
    assign masked_low = masked_req & (~masked_req + NUM_CH'(1));
    assign req_low    = req & (~req + NUM_CH'(1));

    // Nothing at or above the pointer means the scan wraps to the lowest requester overall.
    assign grant = (|masked_req) ? masked_low : req_low;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel valid/ready multiplexer with round-robin or fixed-priority arbitration
// feeding a single full-throughput output register.
module arb_mux_reg
    import arb_mux_reg_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int CH_W   = clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    fixed_prio,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              load_ok;
    logic              transfer;
    logic [WIDTH-1:0]  gated_data [NUM_CH];
    logic [WIDTH-1:0]  sel_data;

    logic              out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]  out_data_reg,  out_data_next;
    logic [CH_W-1:0]   out_ch_reg,    out_ch_next;
    logic [CH_W-1:0]   rr_ptr_reg,    rr_ptr_next;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req        (in_valid),
        .ptr        (rr_ptr_reg),
        .fixed_prio (fixed_prio),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // The register may load whenever it is empty or its word leaves this same cycle.
    assign load_ok  = !out_valid_reg || out_ready;
    assign in_ready = rst ? '0 : (grant & {NUM_CH{load_ok}});
    assign transfer = |(in_valid & in_ready);

    // One-hot grant lets the data select be a plain AND-OR tree.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_gate
            assign gated_data[gi] = in_data[gi*WIDTH +: WIDTH] & {WIDTH{grant[gi]}};
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_data = sel_data | gated_data[i];
        end
    end

    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_ch_next    = out_ch_reg;
        if (transfer) begin
            out_valid_next = 1'b1;
            out_data_next  = sel_data;
            out_ch_next    = grant_idx;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // The pointer only advances on round-robin grants; fixed mode leaves it parked.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (transfer && !fixed_prio) begin
            rr_ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_ch_reg    <= out_ch_next;
            rr_ptr_reg    <= rr_ptr_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Self-checking bench for arb_mux_reg: directed scenarios on a 4x32 instance, then
// routing sweeps and randomized traffic on 4x32, 2x64 and 32x8 instances.
module tb_arb_mux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          sel;
    logic [63:0] drv_data [32];
    logic [31:0] drv_valid;
    logic        drv_fixed;
    logic        drv_oready;

    logic [127:0] in_data0;
    logic [31:0]  out_data0;
    logic [1:0]   out_ch0;
    logic         out_valid0;
    logic [3:0]   in_ready0;

    logic [127:0] in_data1;
    logic [63:0]  out_data1;
    logic [0:0]   out_ch1;
    logic         out_valid1;
    logic [1:0]   in_ready1;

    logic [255:0] in_data2;
    logic [7:0]   out_data2;
    logic [4:0]   out_ch2;
    logic         out_valid2;
    logic [31:0]  in_ready2;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pack0
            assign in_data0[gi*32 +: 32] = drv_data[gi][31:0];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_pack1
            assign in_data1[gi*64 +: 64] = drv_data[gi];
        end
        for (genvar gi = 0; gi < 32; gi++) begin : g_pack2
            assign in_data2[gi*8 +: 8] = drv_data[gi][7:0];
        end
    endgenerate

    arb_mux_reg #(.NUM_CH(4), .WIDTH(32)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(drv_valid[3:0]),
        .in_ready(in_ready0), .fixed_prio(drv_fixed), .out_data(out_data0),
        .out_ch(out_ch0), .out_valid(out_valid0), .out_ready(drv_oready)
    );

    arb_mux_reg #(.NUM_CH(2), .WIDTH(64)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(drv_valid[1:0]),
        .in_ready(in_ready1), .fixed_prio(drv_fixed), .out_data(out_data1),
        .out_ch(out_ch1), .out_valid(out_valid1), .out_ready(drv_oready)
    );

    arb_mux_reg #(.NUM_CH(32), .WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(drv_valid),
        .in_ready(in_ready2), .fixed_prio(drv_fixed), .out_data(out_data2),
        .out_ch(out_ch2), .out_valid(out_valid2), .out_ready(drv_oready)
    );

    logic        obs_valid;
    logic [63:0] obs_data;
    logic [4:0]  obs_ch;
    logic [31:0] obs_ready;

    always_comb begin
        obs_valid = 1'b0;
        obs_data  = '0;
        obs_ch    = '0;
        obs_ready = '0;
        case (sel)
            0: begin
                obs_valid = out_valid0;
                obs_data  = {32'd0, out_data0};
                obs_ch    = {3'd0, out_ch0};
                obs_ready = {28'd0, in_ready0};
            end
            1: begin
                obs_valid = out_valid1;
                obs_data  = out_data1;
                obs_ch    = {4'd0, out_ch1};
                obs_ready = {30'd0, in_ready1};
            end
            default: begin
                obs_valid = out_valid2;
                obs_data  = {56'd0, out_data2};
                obs_ch    = out_ch2;
                obs_ready = in_ready2;
            end
        endcase
    end

    int n_tests;
    int n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: output word, its channel and the rotation start point, plus a
    // scoreboard of accepted words in acceptance order.
    typedef struct {
        int          ch;
        logic [63:0] data;
    } word_t;

    bit          m_valid;
    logic [63:0] m_data;
    int          m_ch;
    int          m_rr;
    int          m_n;
    int          m_w;
    int          last_g;
    word_t       sb[$];

    int cfg_n [3] = '{4, 2, 32};
    int cfg_w [3] = '{32, 64, 8};

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_rr    = 0;
        sb.delete();
    endtask

    function automatic int pick(input logic [31:0] v, input bit fx, input int rr, input int n);
        if (fx) begin
            for (int i = 0; i < n; i++) if (v[i]) return i;
        end else begin
            for (int k = 0; k < n; k++) if (v[(rr + k) % n]) return (rr + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rand_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        if (m_w < 64) r = r & ((64'd1 << m_w) - 64'd1);
        return r;
    endfunction

    // One clock: check outputs on the falling edge, advance the model, return 1 after the rise.
    task automatic step();
        int    g;
        bit    load;
        logic [31:0] exp_rdy;
        word_t w;
        @(negedge clk);
        g       = pick(drv_valid, drv_fixed, m_rr, m_n);
        load    = !m_valid || drv_oready;
        exp_rdy = (g >= 0 && load) ? (32'd1 << g) : 32'd0;
        chk("in_ready", 64'(obs_ready), 64'(exp_rdy));
        chk("out_valid", 64'(obs_valid), 64'(m_valid));
        chk("out_data", obs_data, m_data);
        chk("out_ch", 64'(obs_ch), 64'(m_ch));
        if (m_valid && drv_oready && sb.size() > 0) begin
            w = sb.pop_front();
            chk("sb_data", obs_data, w.data);
            chk("sb_ch", 64'(obs_ch), 64'(w.ch));
        end
        last_g = -1;
        if (g >= 0 && load) begin
            m_valid = 1'b1;
            m_data  = drv_data[g];
            m_ch    = g;
            if (!drv_fixed) m_rr = (g + 1) % m_n;
            w.ch   = g;
            w.data = drv_data[g];
            sb.push_back(w);
            last_g = g;
        end else if (m_valid && drv_oready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        drv_valid  = '0;
        drv_oready = 1'b1;
        step();
        step();
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic rand_cycles(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            step();
            for (int i = 0; i < m_n; i++) begin
                if (!drv_valid[i] || i == last_g) begin
                    drv_valid[i] = ($urandom_range(99, 0) < 40);
                    drv_data[i]  = rand_word();
                end
            end
            drv_oready = ($urandom_range(99, 0) < 70);
            if ($urandom_range(99, 0) < 5) drv_fixed = ~drv_fixed;
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        sel        = 0;
        m_n        = 4;
        m_w        = 32;
        drv_fixed  = 1'b0;
        drv_oready = 1'b1;
        drv_valid  = 32'hF;
        for (int i = 0; i < 32; i++) drv_data[i] = '0;
        rst = 1'b1;
        model_reset();

        // Reset state while requests are pending
        #12;
        chk("rst_valid", 64'(obs_valid), 64'd0);
        chk("rst_data", obs_data, 64'd0);
        chk("rst_ch", 64'(obs_ch), 64'd0);
        chk("rst_ready", 64'(obs_ready), 64'd0);
        drv_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset with a word in flight
        drv_oready  = 1'b0;
        drv_valid   = 32'h2;
        drv_data[1] = 64'h1111_1111;
        step();
        drv_valid   = 32'h8;
        drv_data[3] = 64'h3333_3333;
        drv_oready  = 1'b1;
        chk("pre_rst_valid", 64'(obs_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(obs_valid), 64'd0);
        chk("arst_data", obs_data, 64'd0);
        chk("arst_ch", 64'(obs_ch), 64'd0);
        chk("arst_ready", 64'(obs_ready), 64'd0);
        model_reset();
        drv_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drv_valid   = 32'h4;
        drv_data[2] = 64'hDEAD_BEEF;
        step();
        drv_valid = '0;
        chk("post_rst_valid", 64'(obs_valid), 64'd1);
        chk("post_rst_data", obs_data, 64'hDEAD_BEEF);
        chk("post_rst_ch", 64'(obs_ch), 64'd2);

        // Round-robin fairness from a fresh pointer
        do_reset();
        drv_fixed  = 1'b0;
        drv_oready = 1'b1;
        for (int i = 0; i < 4; i++) drv_data[i] = 64'hA0 + 64'(i);
        drv_valid = 32'hF;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_seq_ch", 64'(obs_ch), 64'(k % 4));
            chk("rr_seq_valid", 64'(obs_valid), 64'd1);
        end

        // Fixed priority, then drop the winner
        drv_fixed = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fix_ch", 64'(obs_ch), 64'd0);
        end
        drv_valid = 32'hE;
        step();
        chk("fix_drop_ch", 64'(obs_ch), 64'd1);

        // Backpressure with ch1 and ch3 requesting (pointer parked at 2)
        drv_fixed   = 1'b0;
        drv_valid   = 32'hA;
        drv_data[1] = 64'hB1;
        drv_data[3] = 64'hB3;
        step();
        chk("bp_first_ch", 64'(obs_ch), 64'd3);
        drv_data[3] = 64'hB4;
        drv_oready  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_ch", 64'(obs_ch), 64'd3);
            chk("bp_hold_data", obs_data, 64'hB3);
            chk("bp_ready", 64'(obs_ready), 64'd0);
        end
        drv_oready = 1'b1;
        step();
        chk("bp_resume_ch", 64'(obs_ch), 64'd1);
        chk("bp_resume_data", obs_data, 64'hB1);

        // Wrap-around: park pointer at 3, then ch3 and ch0 compete
        drv_valid   = 32'h4;
        drv_data[2] = 64'hC2;
        step();
        drv_valid   = 32'h9;
        drv_data[3] = 64'hC3;
        drv_data[0] = 64'hC0;
        step();
        chk("wrap_first_ch", 64'(obs_ch), 64'd3);
        step();
        chk("wrap_second_ch", 64'(obs_ch), 64'd0);
        drain();

        // Per-configuration routing sweep and randomized traffic
        for (int c = 0; c < 3; c++) begin
            sel        = c;
            m_n        = cfg_n[c];
            m_w        = cfg_w[c];
            drv_valid  = '0;
            drv_fixed  = 1'b0;
            drv_oready = 1'b1;
            do_reset();
            for (int i = 0; i < m_n; i++) begin
                drv_valid   = 32'd1 << i;
                drv_data[i] = rand_word();
                step();
                drv_valid = '0;
                chk("route_ch", 64'(obs_ch), 64'(i));
                chk("route_data", obs_data, drv_data[i]);
            end
            rand_cycles(400);
            drv_fixed = 1'b0;
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
